// File: rtl/i2c_master_ctrl_if.sv
// i2c_master_ctrl_if: request/response and open-drain pin bundle for i2c_master_ctrl
// master modport: controller view (requests and line sense in; strobes, status, pin pulls out)
// slave modport : requester/bus view of the same signals
interface i2c_master_ctrl_if #(
  parameter int LEN_W = 3
);
  logic             start;
  logic             rw;
  logic [6:0]       dev_addr;
  logic [7:0]       mem_addr;
  logic [LEN_W-1:0] len;
  logic [7:0]       wdata;
  logic             wdata_req;
  logic [7:0]       rdata;
  logic             rdata_valid;
  logic             busy;
  logic             done;
  logic             nack_err;
  logic             scl_oe;
  logic             scl_i;
  logic             sda_oe;
  logic             sda_i;
  modport master (
    input  start, rw, dev_addr, mem_addr, len, wdata, scl_i, sda_i,
    output wdata_req, rdata, rdata_valid, busy, done, nack_err, scl_oe, sda_oe
  );
  modport slave (
    output start, rw, dev_addr, mem_addr, len, wdata, scl_i, sda_i,
    input  wdata_req, rdata, rdata_valid, busy, done, nack_err, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: I2C master running START, device/memory address, burst data and STOP phases
// Ports: clk, reset (async, active-high), bus (i2c_master_ctrl_if.master: request, strobes, status, SCL/SDA pulls)
// Optional: define I2C_CLOCK_STRETCH_EN to hold the P1 phase while the slave keeps SCL low
module i2c_master_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BURST = 4,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              reset,
  i2c_master_ctrl_if.master bus
);
  localparam int CW = $clog2(CLK_DIV + 1);
  typedef enum logic [3:0] {IDLE, START, DEV, DACK, MEM, MACK, WDATA, WACK, RDATA, RACK, STOP} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       ph_q, ph_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d, mem_q, mem_d, rdata_q, rdata_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic             rw_q, rw_d, nack_q, nack_d, rv_q, rv_d;
  logic             hold, tick, samp, eob, more, ack_slot, data_bit;
`ifdef I2C_CLOCK_STRETCH_EN
  assign hold = ph_q == 2'd1 && !bus.scl_i;
`else
  logic unused_scl;
  assign unused_scl = bus.scl_i;
  assign hold = 1'b0;
`endif
  assign tick     = cnt_q == CW'(CLK_DIV - 1) && !hold;
  assign samp     = tick && ph_q == 2'd1;
  assign eob      = tick && ph_q == 2'd3;
  // left_q counts bytes not yet transferred; it drops at the end of each data byte
  assign more     = left_q != '0;
  assign ack_slot = state_q == DACK || state_q == MACK || state_q == WACK;
  assign data_bit = state_q == DEV || state_q == MEM || state_q == WDATA || state_q == RDATA;
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(!hold);
    ph_d    = state_q == IDLE ? 2'd0 : ph_q + 2'(tick);
    bit_d   = bit_q;
    sh_d    = sh_q;
    mem_d   = mem_q;
    rdata_d = rdata_q;
    left_d  = left_q;
    rw_d    = rw_q;
    nack_d  = nack_q;
    rv_d    = 1'b0;
    if (state_q == IDLE && bus.start) begin
      state_d = START;
      sh_d    = {bus.dev_addr, bus.rw};
      mem_d   = bus.mem_addr;
      left_d  = bus.len;
      rw_d    = bus.rw;
      nack_d  = 1'b0;
      bit_d   = 3'd0;
    end
    if (samp && state_q == RDATA)
      sh_d = {sh_q[6:0], bus.sda_i};
    // a NACK aborts the slot right at the sample point and heads straight for STOP
    if (samp && ack_slot && bus.sda_i) begin
      nack_d  = 1'b1;
      state_d = STOP;
      ph_d    = 2'd0;
    end else if (eob && data_bit) begin
      bit_d = bit_q + 3'd1;
      if (state_q != RDATA)
        sh_d = {sh_q[6:0], 1'b0};
      if (bit_q == 3'd7) begin
        state_d = state_q == DEV ? DACK : state_q == MEM ? MACK : state_q == WDATA ? WACK : RACK;
        left_d  = state_q == WDATA || state_q == RDATA ? left_q - LEN_W'(1) : left_q;
        rdata_d = state_q == RDATA ? sh_q : rdata_q;
        rv_d    = state_q == RDATA;
      end
    end else if (eob) begin
      case (state_q)
        START: state_d = DEV;
        DACK: begin
          state_d = MEM;
          sh_d    = mem_q;
        end
        MACK, WACK, RACK: begin
          state_d = !more ? STOP : rw_q ? RDATA : WDATA;
          sh_d    = more && !rw_q ? bus.wdata : sh_q;
        end
        STOP: state_d = IDLE;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= 2'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      mem_q   <= 8'd0;
      rdata_q <= 8'd0;
      left_q  <= '0;
      rw_q    <= 1'b0;
      nack_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
      left_q  <= left_d;
      rw_q    <= rw_d;
      nack_q  <= nack_d;
      rv_q    <= rv_d;
    end
  end
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = state_q == STOP && eob;
  assign bus.wdata_req   = eob && (state_q == MACK || state_q == WACK) && more && !rw_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rv_q;
  assign bus.nack_err    = nack_q;
  // START/STOP move SDA only while SCL is released; data bits pull SCL low in P0 and P3
  assign bus.scl_oe = state_q == IDLE ? 1'b0 : state_q == START ? ph_q == 2'd3 :
                      state_q == STOP ? ph_q == 2'd0 : ph_q == 2'd0 || ph_q == 2'd3;
  assign bus.sda_oe = (state_q == DEV || state_q == MEM || state_q == WDATA) ? !sh_q[7] :
                      state_q == START ? ph_q[1] : state_q == STOP ? !ph_q[1] :
                      state_q == RACK && more;
endmodule
